// File: rtl/neuron_layer_train_sequencer.sv
// ============================================================================
// neuron_layer_train_sequencer: steps one neuron layer through forward/learn
// phases per sample, counting samples per epoch and epochs per run.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_layer_train_sequencer #(
   parameter int N         = 16,
   parameter int M         = 28,
   parameter int SETTLE    = 2,
   parameter int SAMPLES_W = 8,
   parameter int EPOCHS_W  = 8,
   parameter int DATA_W    = 8
) (
   input  logic                          clock_i,
   input  logic                          reset_ni,
   input  logic                          start_i,
   input  logic                          train_en_i,
   input  logic [SAMPLES_W-1:0]          num_samples_i,
   input  logic [EPOCHS_W-1:0]           num_epochs_i,
   input  logic                          s_valid_i,
   output logic                          s_ready_o,
   input  logic [N-1:0][DATA_W-1:0]      s_in_i,
   input  logic [M-1:0][DATA_W-1:0]      s_target_i,
   output logic                          layer_valid_o,
   output logic                          layer_learn_o,
   output logic [N-1:0][DATA_W-1:0]      layer_in_o,
   output logic [M-1:0][DATA_W-1:0]      layer_expected_out_o,
   input  logic [M-1:0][DATA_W-1:0]      layer_out_i,
   output logic                          r_valid_o,
   output logic [M-1:0][DATA_W-1:0]      r_out_o,
   output logic                          busy_o,
   output logic                          epoch_done_o,
   output logic                          done_o,
   output logic [SAMPLES_W-1:0]          sample_idx_o,
   output logic [EPOCHS_W-1:0]           epoch_idx_o
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT_S = 3'd1,
      FWD    = 3'd2,
      LEARN  = 3'd3,
      NEXT   = 3'd4
   } state_e;

   state_e                      state_q, state_d;
   logic                        train_en_q, train_en_d;
   logic [SAMPLES_W-1:0]        num_samples_q, num_samples_d;
   logic [EPOCHS_W-1:0]         num_epochs_q, num_epochs_d;
   logic [SAMPLES_W-1:0]        sample_idx_q, sample_idx_d;
   logic [EPOCHS_W-1:0]         epoch_idx_q, epoch_idx_d;
   logic [CNT_W-1:0]            settle_q, settle_d;
   logic [N-1:0][DATA_W-1:0]    layer_in_q, layer_in_d;
   logic [M-1:0][DATA_W-1:0]    layer_exp_q, layer_exp_d;
   logic [M-1:0][DATA_W-1:0]    r_out_q, r_out_d;
   logic                        epoch_done_q, epoch_done_d;
   logic                        done_q, done_d;
   logic                        capture;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= IDLE;
         train_en_q    <= 1'b0;
         num_samples_q <= '0;
         num_epochs_q  <= '0;
         sample_idx_q  <= '0;
         epoch_idx_q   <= '0;
         settle_q      <= '0;
         layer_in_q    <= '0;
         layer_exp_q   <= '0;
         r_out_q       <= '0;
         epoch_done_q  <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         train_en_q    <= train_en_d;
         num_samples_q <= num_samples_d;
         num_epochs_q  <= num_epochs_d;
         sample_idx_q  <= sample_idx_d;
         epoch_idx_q   <= epoch_idx_d;
         settle_q      <= settle_d;
         layer_in_q    <= layer_in_d;
         layer_exp_q   <= layer_exp_d;
         r_out_q       <= r_out_d;
         epoch_done_q  <= epoch_done_d;
         done_q        <= done_d;
      end
   end

   // The result is presented in the last settle cycle, so r_out forwards
   // layer_out during the pulse and holds the captured copy afterwards.
   assign capture = (state_q == FWD) && (settle_q == '0);

   always_comb begin
      state_d       = state_q;
      train_en_d    = train_en_q;
      num_samples_d = num_samples_q;
      num_epochs_d  = num_epochs_q;
      sample_idx_d  = sample_idx_q;
      epoch_idx_d   = epoch_idx_q;
      settle_d      = settle_q;
      layer_in_d    = layer_in_q;
      layer_exp_d   = layer_exp_q;
      r_out_d       = r_out_q;
      epoch_done_d  = 1'b0;
      done_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               train_en_d    = train_en_i;
               num_samples_d = num_samples_i;
               num_epochs_d  = num_epochs_i;
               sample_idx_d  = '0;
               epoch_idx_d   = '0;
               if ((num_samples_i == '0) || (num_epochs_i == '0)) begin
                  done_d = 1'b1;
               end else begin
                  state_d = WAIT_S;
               end
            end
         end
         WAIT_S: begin
            if (s_valid_i) begin
               layer_in_d  = s_in_i;
               layer_exp_d = s_target_i;
               settle_d    = CNT_W'(SETTLE - 1);
               state_d     = FWD;
            end
         end
         FWD: begin
            if (capture) begin
               r_out_d = layer_out_i;
               state_d = train_en_q ? LEARN : NEXT;
            end else begin
               settle_d = settle_q - CNT_W'(1);
            end
         end
         LEARN: begin
            state_d = NEXT;
         end
         NEXT: begin
            if (sample_idx_q == num_samples_q - SAMPLES_W'(1)) begin
               sample_idx_d = '0;
               epoch_done_d = 1'b1;
               if (epoch_idx_q == num_epochs_q - EPOCHS_W'(1)) begin
                  epoch_idx_d = '0;
                  done_d      = 1'b1;
                  state_d     = IDLE;
               end else begin
                  epoch_idx_d = epoch_idx_q + EPOCHS_W'(1);
                  state_d     = WAIT_S;
               end
            end else begin
               sample_idx_d = sample_idx_q + SAMPLES_W'(1);
               state_d      = WAIT_S;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Valid/learn decode straight from state so an async reset drops them at once.
   assign s_ready_o            = (state_q == WAIT_S);
   assign layer_valid_o        = (state_q == FWD) || (state_q == LEARN);
   assign layer_learn_o        = (state_q == LEARN);
   assign layer_in_o           = layer_in_q;
   assign layer_expected_out_o = layer_exp_q;
   assign r_valid_o            = capture;
   assign r_out_o              = capture ? layer_out_i : r_out_q;
   assign busy_o               = (state_q != IDLE);
   assign epoch_done_o         = epoch_done_q;
   assign done_o               = done_q;
   assign sample_idx_o         = sample_idx_q;
   assign epoch_idx_o          = epoch_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_neuron_layer_train_sequencer.sv
// ============================================================================
// tb_neuron_layer_train_sequencer: table-driven runs checked cycle by cycle
// against a timeline model of the sample/epoch schedule.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neuron_layer_train_sequencer;

   localparam int N      = 16;
   localparam int M      = 28;
   localparam int SETTLE = 2;
   localparam int SW     = 8;
   localparam int EW     = 8;
   localparam int DW     = 8;

   typedef logic [N-1:0][DW-1:0] vin_t;
   typedef logic [M-1:0][DW-1:0] vout_t;

   typedef struct {
      bit tr;
      int ns;
      int ne;
      int hold;
      int vprob;
      int e_rv;
      int e_ll;
      int e_ed;
      int e_dn;
   } vec_t;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          train_en = 1'b0;
   logic [SW-1:0] num_samples = '0;
   logic [EW-1:0] num_epochs = '0;
   logic          s_valid = 1'b0;
   vin_t          s_in = '0;
   vout_t         s_target = '0;
   logic          s_ready, layer_valid, layer_learn, r_valid, busy, epoch_done, done;
   vin_t          layer_in;
   vout_t         layer_exp, layer_out, r_out;
   logic [SW-1:0] sample_idx;
   logic [EW-1:0] epoch_idx;

   int    n_chk = 0;
   int    n_fail = 0;
   vin_t  m_in = '0;
   vout_t m_tg = '0;

   always #5 clock = ~clock;

   neuron_layer_train_sequencer #(
      .N(N), .M(M), .SETTLE(SETTLE), .SAMPLES_W(SW), .EPOCHS_W(EW), .DATA_W(DW)
   ) dut (
      .clock_i(clock), .reset_ni(reset_n), .start_i(start), .train_en_i(train_en),
      .num_samples_i(num_samples), .num_epochs_i(num_epochs),
      .s_valid_i(s_valid), .s_ready_o(s_ready), .s_in_i(s_in), .s_target_i(s_target),
      .layer_valid_o(layer_valid), .layer_learn_o(layer_learn), .layer_in_o(layer_in),
      .layer_expected_out_o(layer_exp), .layer_out_i(layer_out),
      .r_valid_o(r_valid), .r_out_o(r_out), .busy_o(busy),
      .epoch_done_o(epoch_done), .done_o(done),
      .sample_idx_o(sample_idx), .epoch_idx_o(epoch_idx)
   );

   // Stand-in for the neuron layer: a fixed, input-dependent mapping.
   function automatic vout_t layer_fn(input vin_t v);
      vout_t o;
      for (int j = 0; j < M; j++) o[j] = v[j % N] + DW'(j * 7 + 3);
      return o;
   endfunction

   always_comb layer_out = layer_fn(layer_in);

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run(input vec_t v);
      int    cyc = 0, acc = -1, gap = 0, sidx = 0, eidx = 0;
      int    done_at = -1, edone_at = -1;
      int    c_rv = 0, c_ll = 0, c_ed = 0, c_dn = 0;
      int    lns = 0, lne = 0;
      bit    ltr = 0, active = 0, started = 0, finished = 0;
      bit    e_rv, e_ll, e_lv;
      while (cyc < 5000) begin
         @(negedge clock);
         if (acc >= 0 && cyc == acc + gap) begin
            acc = -1;
            if (sidx == lns - 1) begin
               sidx = 0;
               edone_at = cyc;
               if (eidx == lne - 1) begin
                  eidx = 0;
                  done_at = cyc;
                  active = 0;
               end else eidx++;
            end else sidx++;
         end
         e_rv = (acc >= 0) && (cyc == acc + SETTLE);
         e_ll = ltr && (acc >= 0) && (cyc == acc + SETTLE + 1);
         e_lv = (acc >= 0) && (cyc > acc) && (cyc <= acc + SETTLE + (ltr ? 1 : 0));
         chk("s_ready", 256'(s_ready), 256'(active && acc < 0));
         chk("busy", 256'(busy), 256'(active));
         chk("layer_valid", 256'(layer_valid), 256'(e_lv));
         chk("layer_learn", 256'(layer_learn), 256'(e_ll));
         chk("r_valid", 256'(r_valid), 256'(e_rv));
         if (e_rv) chk("r_out", 256'(r_out), 256'(layer_fn(m_in)));
         chk("epoch_done", 256'(epoch_done), 256'(cyc == edone_at));
         chk("done", 256'(done), 256'(cyc == done_at));
         chk("sample_idx", 256'(sample_idx), 256'(sidx));
         chk("epoch_idx", 256'(epoch_idx), 256'(eidx));
         chk("layer_in", 256'(layer_in), 256'(m_in));
         chk("layer_expected_out", 256'(layer_exp), 256'(m_tg));
         c_rv += int'(r_valid);
         c_ll += int'(layer_learn);
         c_ed += int'(epoch_done);
         c_dn += int'(done);
         if (started && !active && cyc > done_at) begin
            finished = 1;
            break;
         end
         if (!started) begin
            start = 1'b1;
            train_en = v.tr;
            num_samples = SW'(v.ns);
            num_epochs = EW'(v.ne);
         end else begin
            start = active && ($urandom_range(0, 3) == 0);
            train_en = 1'($urandom);
            num_samples = SW'($urandom);
            num_epochs = EW'($urandom);
         end
         s_valid = (cyc > v.hold) && ($urandom_range(1, 100) <= v.vprob);
         for (int k = 0; k < N; k++) s_in[k] = DW'($urandom);
         for (int k = 0; k < M; k++) s_target[k] = DW'($urandom);
         if (active && acc < 0 && s_valid) begin
            acc = cyc;
            gap = SETTLE + (ltr ? 3 : 2);
            m_in = s_in;
            m_tg = s_target;
         end
         if (!started) begin
            started = 1;
            ltr = v.tr;
            lns = v.ns;
            lne = v.ne;
            if (v.ns == 0 || v.ne == 0) done_at = cyc + 1;
            else active = 1;
         end
         cyc++;
      end
      start = 1'b0;
      s_valid = 1'b0;
      chk("run_finished", 256'(finished), 256'(1));
      chk("r_valid_count", 256'(c_rv), 256'(v.e_rv));
      chk("learn_count", 256'(c_ll), 256'(v.e_ll));
      chk("epoch_done_count", 256'(c_ed), 256'(v.e_ed));
      chk("done_count", 256'(c_dn), 256'(v.e_dn));
   endtask

   initial begin
      vec_t tbl[7];
      bit   seen;
      tbl[0] = '{1'b1, 3,   2, 0,  100, 6,   6, 2, 1};
      tbl[1] = '{1'b0, 4,   1, 0,  100, 4,   0, 1, 1};
      tbl[2] = '{1'b1, 2,   1, 10, 100, 2,   2, 1, 1};
      tbl[3] = '{1'b0, 0,   5, 0,  100, 0,   0, 0, 1};
      tbl[4] = '{1'b1, 4,   0, 0,  100, 0,   0, 0, 1};
      tbl[5] = '{1'b1, 3,   3, 0,  40,  9,   9, 3, 1};
      tbl[6] = '{1'b0, 255, 1, 0,  100, 255, 0, 1, 1};

      repeat (3) @(negedge clock);
      chk("rst_s_ready", 256'(s_ready), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_layer_valid", 256'(layer_valid), 256'(0));
      chk("rst_layer_learn", 256'(layer_learn), 256'(0));
      chk("rst_r_valid", 256'(r_valid), 256'(0));
      chk("rst_r_out", 256'(r_out), 256'(0));
      chk("rst_done", 256'({epoch_done, done}), 256'(0));
      chk("rst_idx", 256'({sample_idx, epoch_idx}), 256'(0));
      chk("rst_vectors", 256'({layer_in, layer_exp}), 256'(0));
      reset_n = 1'b1;

      for (int i = 0; i < 7; i++) run(tbl[i]);

      // Async reset landing in the middle of the learn pulse.
      @(negedge clock);
      start = 1'b1; train_en = 1'b1; num_samples = SW'(3); num_epochs = EW'(1);
      s_valid = 1'b1;
      for (int k = 0; k < N; k++) s_in[k] = DW'($urandom);
      @(negedge clock);
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         seen = layer_learn;
      end
      chk("learn_reached", 256'(seen), 256'(1));
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_learn", 256'(layer_learn), 256'(0));
      chk("mid_rst_valid", 256'(layer_valid), 256'(0));
      chk("mid_rst_busy", 256'(busy), 256'(0));
      chk("mid_rst_layer_in", 256'(layer_in), 256'(0));
      s_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_rst_busy", 256'(busy), 256'(0));
      chk("post_rst_ready", 256'(s_ready), 256'(0));
      m_in = '0;
      m_tg = '0;
      run(tbl[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/neuron_layer_train_sequencer.md
Name: neuron_layer_train_sequencer

Overview:
- Sequences one neuron_learn layer (typically the 28-neuron layer) through forward and learn phases, one sample at a time.
- Accepts samples (input vector + target vector) over a valid/ready handshake and registers them onto the layer inputs.
- Waits a programmable settle time, captures the layer outputs, then optionally pulses learn.
- Counts samples per epoch and epochs per run, and reports completion.

Parameters:
- N, 16, layer input width (elements of zero2one_t).
- M, 28, layer output/neuron count.
- SETTLE, 2, cycles between driving layer_valid and capturing layer_out (minimum 1).
- SAMPLES_W, 8, width of the samples-per-epoch count.
- EPOCHS_W, 8, width of the epoch count.

Ports:
- clock, input, 1, the single clock.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, starts a run when in IDLE.
- train_en, input, 1, sampled at start: 1 = forward+learn, 0 = inference only.
- num_samples, input, SAMPLES_W, samples per epoch, sampled at start.
- num_epochs, input, EPOCHS_W, epochs per run, sampled at start.
- s_valid, input, 1, sample offered.
- s_ready, output, 1, sequencer accepts the sample this cycle.
- s_in, input, N x zero2one_t, sample input vector.
- s_target, input, M x zero2one_t, sample expected output.
- layer_valid, output, 1, to layer valid.
- layer_learn, output, 1, to layer learn.
- layer_in, output, N x zero2one_t, to layer in.
- layer_expected_out, output, M x zero2one_t, to layer expected_out.
- layer_out, input, M x zero2one_t, from layer out.
- r_valid, output, 1, result pulse.
- r_out, output, M x zero2one_t, captured layer_out.
- busy, output, 1, high in every state except IDLE.
- epoch_done, output, 1, one-cycle pulse at the end of each epoch.
- done, output, 1, one-cycle pulse at the end of the run.
- sample_idx, output, SAMPLES_W, current sample index.
- epoch_idx, output, EPOCHS_W, current epoch index.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, including all vectors zeroed.
  - State IDLE, counters 0, latched config 0.
- States: IDLE, WAIT_S, FWD, LEARN, NEXT.
- IDLE:
  - start=1 latches train_en, num_samples and num_epochs, clears both counters, goes to WAIT_S.
  - If num_samples==0 or num_epochs==0: pulse done next cycle and stay in IDLE.
- WAIT_S:
  - s_ready=1 (combinational from state, independent of s_valid).
  - On s_valid&&s_ready: register s_in→layer_in and s_target→layer_expected_out, set layer_valid=1, load settle counter=SETTLE-1, go to FWD.
  - s_ready is 0 in all other states.
- FWD:
  - layer_valid stays 1; settle counter decrements.
  - When counter==0: capture layer_out→r_out and pulse r_valid for 1 cycle.
  - Then go to LEARN if train_en, else to NEXT with layer_valid=0.
- LEARN:
  - Exactly one cycle with layer_valid=1 and layer_learn=1.
  - layer_in and layer_expected_out are unchanged.
  - Next cycle both signals drop to 0; go to NEXT.
- NEXT:
  - If sample_idx==num_samples-1: sample_idx←0 and pulse epoch_done.
    - If epoch_idx==num_epochs-1: pulse done, epoch_idx←0, go to IDLE.
    - Otherwise epoch_idx+1, go to WAIT_S.
  - Otherwise sample_idx+1, go to WAIT_S.
  - epoch_done and done coincide on the final sample.
- Latency from the accept cycle:
  - r_valid asserts SETTLE cycles after accept.
  - layer_learn asserts SETTLE+1 cycles after accept.
  - Next s_ready: SETTLE+3 cycles after accept (train_en=1) or SETTLE+2 (train_en=0).
- Data hold: layer_in and layer_expected_out hold their last values outside FWD/LEARN; they are not cleared.
- start while busy is ignored. Config inputs are ignored after latch.
- Counters compare against latched values only, so there is no wrap-around hazard. Maximum values 2^W-1 are supported.
- reset_n asserted mid-run (including during LEARN): layer_learn and layer_valid drop immediately. No partial learn pulse is extended.

Test Plan:
- Reset mid-LEARN: assert reset_n=0 while layer_learn=1 → layer_learn=0 and layer_valid=0 immediately; after release state is IDLE and busy=0.
- Train run: start with train_en=1, num_samples=3, num_epochs=2, s_valid tied high, SETTLE=2 →
  - 6 r_valid pulses and 6 one-cycle layer_learn pulses, each one cycle after its r_valid.
  - epoch_done after samples 3 and 6.
  - done coincident with the 2nd epoch_done.
  - Accepts 5 cycles apart.
- Inference: train_en=0, num_samples=4, num_epochs=1 → 4 r_valid pulses, layer_learn never 1, accepts 4 cycles apart, done after the 4th.
- Backpressure: s_valid low for 10 cycles in WAIT_S → s_ready stays 1, layer_valid stays 0; the sample is accepted on the first cycle s_valid=1, and r_out equals the layer output for that sample.
- Zero config: start with num_samples=0 → done pulses next cycle; busy never 1; s_ready never 1.
- start asserted while busy → ignored; sample_idx/epoch_idx sequence unchanged.
